// File: rtl/dps_decoder_24_pkg.sv
// dps_decoder_24_pkg: widths and the per-bit Fibonacci weight table of the 24-bit DPS code
package dps_decoder_24_pkg;
  localparam int CODE_W = 24;
  localparam int DATA_W = 18;
  localparam logic [DATA_W-1:0] DPS_W [CODE_W] = '{
    18'd1,     18'd1,     18'd2,     18'd3,     18'd5,     18'd8,
    18'd13,    18'd21,    18'd34,    18'd55,    18'd89,    18'd144,
    18'd233,   18'd377,   18'd610,   18'd987,   18'd1597,  18'd2584,
    18'd4181,  18'd6765,  18'd10946, 18'd17711, 18'd57314, 18'd46368
  };
endpackage

// File: rtl/dps_decoder_24_group_sum.sv
// dps_group_sum: weighted sum of one 8-bit codeword slice starting at bit BASE
module dps_group_sum
  import dps_decoder_24_pkg::*;
#(
  parameter int BASE = 0
) (
  input  logic [7:0]        slice_i,
  output logic [DATA_W-1:0] sum_o
);
  always_comb begin
    sum_o = '0;
    for (int i = 0; i < 8; i++) sum_o = sum_o + (slice_i[i] ? DPS_W[BASE+i] : '0);
  end
endmodule

// File: rtl/dps_decoder_24.sv
// dps_decoder_24: 3-stage valid/ready pipeline turning a DPS codeword into its weighted binary sum
module dps_decoder_24
  import dps_decoder_24_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [CODE_W-1:0] code_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              out_valid,
  input  logic              out_ready
);
  logic              v1_q, v2_q, v3_q;
  logic              ld1, ld2, ld3;
  logic [CODE_W-1:0] code_q;
  logic [DATA_W-1:0] part_d [3];
  logic [DATA_W-1:0] part_q [3];
  logic [DATA_W-1:0] sum_d, data_q;
  // each stage refills whenever it is empty or its contents move on
  assign ld3 = !v3_q | out_ready;
  assign ld2 = !v2_q | ld3;
  assign ld1 = !v1_q | ld2;
  assign in_ready  = ld1;
  assign out_valid = v3_q;
  assign data_out  = data_q;
  assign sum_d = part_q[0] + part_q[1] + part_q[2];
  for (genvar g = 0; g < 3; g++) begin : grp
    dps_group_sum #(.BASE(8*g)) u_sum (
      .slice_i(code_q[8*g +: 8]),
      .sum_o  (part_d[g])
    );
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      data_q <= '0;
    end else begin
      if (ld1) begin
        v1_q <= in_valid;
        if (in_valid) code_q <= code_in;
      end
      if (ld2) begin
        v2_q <= v1_q;
        if (v1_q) part_q <= part_d;
      end
      if (ld3) begin
        v3_q <= v2_q;
        if (v2_q) data_q <= sum_d;
      end
    end
  end
endmodule

// File: tb/tb_dps_decoder_24.sv
// tb_dps_decoder_24: directed vector table plus scoreboarded streaming, stall and reset sequences
module tb_dps_decoder_24;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] code_in = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [17:0] data_out;
  logic        out_valid;
  logic        out_ready = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;
  int n_out = 0;
  logic took, ov_s;
  int exp_q [$];

  typedef struct {
    logic [23:0] code;
    int          exp;
  } vec_t;
  vec_t tab [$];

  dps_decoder_24 dut (
    .clock    (clock),
    .reset    (reset),
    .code_in  (code_in),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .data_out (data_out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  function automatic int fib(int n);
    int a = 1, b = 1, t;
    for (int i = 3; i <= n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return b;
  endfunction

  function automatic int model(logic [23:0] c);
    int s = 0;
    for (int k = 0; k < 24; k++)
      if (c[k]) s += (k == 0) ? 1 : (k == 22) ? 2 * fib(23) : (k == 23) ? fib(24) : fib(k + 1);
    return s;
  endfunction

  task automatic chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // one clock of traffic; handshakes are logged against the scoreboard just before the edge
  task automatic cyc(logic iv, logic [23:0] c, logic r);
    in_valid  = iv;
    code_in   = c;
    out_ready = r;
    #1;
    took = in_valid && in_ready;
    ov_s = out_valid;
    if (took) exp_q.push_back(model(c));
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) chk("unexpected_output", int'(data_out), -1);
      else chk("stream_data", int'(data_out), exp_q.pop_front());
    end
    tick();
  endtask

  int sweep [24] = '{1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144, 233, 377, 610, 987,
                     1597, 2584, 4181, 6765, 10946, 17711, 57314, 46368};
  logic [23:0] bp [6];
  int idx, cnt, base;

  initial begin
    for (int i = 0; i < 24; i++) tab.push_back('{24'h1 << i, sweep[i]});
    tab.push_back('{24'hFFFFFF, 150049});
    tab.push_back('{24'h000000, 0});
    tab.push_back('{24'h000101, 35});
    tab.push_back('{24'hC00000, 103682});
    tab.push_back('{24'h000F00, 322});

    repeat (3) tick();
    reset = 1'b0;
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_data_out", int'(data_out), 0);
    chk("reset_in_ready", int'(in_ready), 1);

    foreach (tab[i]) begin
      cyc(1'b1, tab[i].code, 1'b1);
      chk("vec_accepted", int'(took), 1);
      cyc(1'b0, '0, 1'b1);
      chk("vec_not_early", int'(out_valid), 0);
      cyc(1'b0, '0, 1'b1);
      chk("vec_valid_at_3", int'(out_valid), 1);
      chk($sformatf("vec_%06h", tab[i].code), int'(data_out), tab[i].exp);
      cyc(1'b0, '0, 1'b1);
    end

    // backpressure: sink stalls from the start, pipeline should absorb exactly three words
    for (int i = 0; i < 6; i++) bp[i] = 24'h1 << (3 * i + 1) | 24'h1;
    idx = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(idx < 6, bp[idx % 6], 1'b0);
      if (took) idx++;
    end
    chk("bp_words_held", idx, 3);
    chk("bp_in_ready_low", int'(in_ready), 0);
    chk("bp_out_valid", int'(out_valid), 1);
    chk("bp_data_hold", int'(data_out), model(bp[0]));
    base = n_out;
    for (int i = 0; i < 30 && n_out - base < 6; i++) begin
      cyc(idx < 6, bp[idx % 6], 1'b1);
      if (took) idx++;
    end
    chk("bp_delivered", n_out - base, 6);
    chk("bp_queue_empty", exp_q.size(), 0);

    // full-rate burst: back-to-back words must never see in_ready drop
    base = n_out;
    cnt = 0;
    for (int i = 0; i < 104; i++) begin
      cyc(i < 100, 24'($urandom), 1'b1);
      if (i < 100 && !took) cnt++;
      if (i == 2) chk("burst_not_before_3", int'(ov_s), 0);
    end
    chk("burst_in_ready_drops", cnt, 0);
    chk("burst_outputs", n_out - base, 100);

    // random traffic on both sides
    for (int i = 0; i < 3000; i++)
      cyc(1'($urandom_range(0, 1)), 24'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) cyc(1'b0, '0, 1'b1);
    chk("random_drained", exp_q.size(), 0);

    // reset with three words in flight
    cyc(1'b1, 24'h123456, 1'b0);
    cyc(1'b1, 24'h654321, 1'b0);
    cyc(1'b1, 24'hABCDEF, 1'b0);
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_q.delete();
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_data_out", int'(data_out), 0);
    chk("midrst_in_ready", int'(in_ready), 1);
    base = n_out;
    for (int i = 0; i < 6; i++) cyc(1'b0, '0, 1'b1);
    chk("midrst_no_stale", n_out - base, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
